// File: rtl/irq_sequencer.sv
// Four-source interrupt sequencer: pending latch, mask, fixed-priority take, reti return.
// Optional IRQ_NEST_EN adds strict-priority preemption with a 4-deep return stack.
module irq_sequencer #(
    parameter int unsigned     PC_W        = 10,
    parameter logic [PC_W-1:0] VEC_TIMER   = 10'h3FA,
    parameter logic [PC_W-1:0] VEC_EXC     = 10'h3FB,
    parameter logic [PC_W-1:0] VEC_PORT    = 10'h3FC,
    parameter logic [PC_W-1:0] VEC_SYSCALL = 10'h3FD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_exc,
    input  logic            req_port,
    input  logic            req_syscall,
    input  logic            req_timer,
    input  logic            mask_we,
    input  logic [3:0]      mask_wdata,
    input  logic [PC_W-1:0] pc_cur,
    input  logic            stall,
    input  logic            reti,
    output logic            irq_take,
    output logic [PC_W-1:0] vec_out,
    output logic            ret_valid,
    output logic [PC_W-1:0] ret_pc,
    output logic [3:0]      pending,
    output logic [3:0]      in_service,
    output logic            busy
);
    localparam int unsigned SRC_W = 4;

    typedef enum logic [1:0] {IDLE, TAKE, SERVICE, RETURN} state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  pending_q, mask_q, in_service_q, win_q;
    logic [SRC_W-1:0]  eligible_c, win_c, top_src_c;
    logic [PC_W-1:0]   vec_out_q, ret_pc_q, top_pc_c;
    logic              irq_take_q, ret_valid_q, busy_q;
    logic              preempt_c, more_c;

    function automatic logic [PC_W-1:0] vec_of(input logic [SRC_W-1:0] s);
        if (s[3]) return VEC_EXC;
        if (s[2]) return VEC_PORT;
        if (s[0]) return VEC_TIMER;
        return VEC_SYSCALL;
    endfunction

    // Exceptions bypass the mask; priority exc > port > timer > syscall
    always_comb begin
        eligible_c = pending_q & (mask_q | 4'b1000);
        win_c      = '0;
        if      (eligible_c[3]) win_c = 4'b1000;
        else if (eligible_c[2]) win_c = 4'b0100;
        else if (eligible_c[0]) win_c = 4'b0001;
        else if (eligible_c[1]) win_c = 4'b0010;
    end

`ifdef IRQ_NEST_EN
    localparam int unsigned STK_D = 4;
    localparam int unsigned PTR_W = 3;

    logic [PC_W-1:0]  pc_stk_q  [STK_D];
    logic [SRC_W-1:0] src_stk_q [STK_D];
    logic [PTR_W-1:0] depth_q;
    logic [1:0]       top_idx_c;

    function automatic logic [2:0] rank(input logic [SRC_W-1:0] s);
        if (s[3]) return 3'd4;
        if (s[2]) return 3'd3;
        if (s[0]) return 3'd2;
        if (s[1]) return 3'd1;
        return 3'd0;
    endfunction

    assign top_idx_c = 2'(depth_q - PTR_W'(1));
    assign top_pc_c  = pc_stk_q[top_idx_c];
    assign top_src_c = src_stk_q[top_idx_c];
    assign more_c    = depth_q > PTR_W'(1);
    assign preempt_c = (win_c != '0) && !stall && (rank(win_c) > rank(in_service_q));

    // Each take pushes the interrupted PC and the source it preempted (none from IDLE)
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < STK_D; i++) begin
                pc_stk_q[i]  <= '0;
                src_stk_q[i] <= '0;
            end
        end else if (state_q == TAKE) begin
            pc_stk_q[depth_q[1:0]]  <= pc_cur;
            src_stk_q[depth_q[1:0]] <= in_service_q;
            depth_q                 <= depth_q + PTR_W'(1);
        end else if (state_q == RETURN) begin
            depth_q <= depth_q - PTR_W'(1);
        end
    end
`else
    logic [PC_W-1:0] saved_pc_q;

    assign top_pc_c  = saved_pc_q;
    assign top_src_c = '0;
    assign more_c    = 1'b0;
    assign preempt_c = 1'b0;

    always_ff @(posedge clk) begin
        if (reset)                saved_pc_q <= '0;
        else if (state_q == TAKE) saved_pc_q <= pc_cur;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_c != '0 && !stall) state_d = TAKE;
            TAKE:    state_d = SERVICE;
            SERVICE: begin
                if (reti)           state_d = RETURN;
                else if (preempt_c) state_d = TAKE;
            end
            RETURN:  state_d = more_c ? SERVICE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath; strobes are asserted in the same cycle the FSM enters TAKE/RETURN
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            mask_q       <= 4'b1111;
            in_service_q <= '0;
            win_q        <= '0;
            vec_out_q    <= '0;
            ret_pc_q     <= '0;
            irq_take_q   <= 1'b0;
            ret_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pending_q   <= (pending_q & ~((state_q == TAKE) ? win_q : 4'b0000))
                         | {req_exc, req_port, req_syscall, req_timer};
            if (mask_we) mask_q <= mask_wdata;
            irq_take_q  <= (state_d == TAKE);
            ret_valid_q <= (state_d == RETURN);
            busy_q      <= (state_d != IDLE);
            if (state_d == TAKE && state_q != TAKE) begin
                win_q     <= win_c;
                vec_out_q <= vec_of(win_c);
            end
            if (state_d == RETURN && state_q != RETURN) ret_pc_q <= top_pc_c;
            if (state_q == TAKE)        in_service_q <= win_q;
            else if (state_q == RETURN) in_service_q <= top_src_c;
        end
    end

    assign irq_take   = irq_take_q;
    assign vec_out    = vec_out_q;
    assign ret_valid  = ret_valid_q;
    assign ret_pc     = ret_pc_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: stimulus queues expected take/return strobes with cycle stamps.
module tb_irq_sequencer;
    localparam int unsigned PC_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_exc, req_port, req_syscall, req_timer;
    logic            mask_we;
    logic [3:0]      mask_wdata;
    logic [PC_W-1:0] pc_cur;
    logic            stall, reti;
    logic            irq_take, ret_valid, busy;
    logic [PC_W-1:0] vec_out, ret_pc;
    logic [3:0]      pending, in_service;

    typedef struct {
        bit              is_ret;
        logic [PC_W-1:0] val;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    irq_sequencer dut (
        .clk(clk), .reset(reset),
        .req_exc(req_exc), .req_port(req_port), .req_syscall(req_syscall), .req_timer(req_timer),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .pc_cur(pc_cur),
        .stall(stall), .reti(reti),
        .irq_take(irq_take), .vec_out(vec_out), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .pending(pending), .in_service(in_service), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic exp_take(input logic [PC_W-1:0] v, input int c);
        exp_t e;
        e.is_ret = 1'b0; e.val = v; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic exp_ret(input logic [PC_W-1:0] v, input int c);
        exp_t e;
        e.is_ret = 1'b1; e.val = v; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the next queued expectation in kind, value and cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (irq_take) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_take actual vec=%h cyc=%0d required none", vec_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_ret || vec_out !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL take actual vec=%h cyc=%0d required ret=%0d val=%h cyc=%0d",
                                 vec_out, cyc, e.is_ret, e.val, e.cyc);
                    end
                end
            end
            if (ret_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ret actual pc=%h cyc=%0d required none", ret_pc, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.is_ret || ret_pc !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL ret actual pc=%h cyc=%0d required ret=%0d val=%h cyc=%0d",
                                 ret_pc, cyc, e.is_ret, e.val, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        {req_exc, req_port, req_syscall, req_timer} = 4'b0000;
        mask_we = 1'b0; mask_wdata = 4'b0000; pc_cur = '0; stall = 1'b0; reti = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        chk("rst_irq_take", 32'(irq_take), 0);
        chk("rst_ret_valid", 32'(ret_valid), 0);
        chk("rst_vec_out", 32'(vec_out), 0);
        chk("rst_ret_pc", 32'(ret_pc), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single timer interrupt and return
        t = cyc; pc_cur = 10'h012; req_timer = 1'b1;
        exp_take(10'h3FA, t + 2);
        step(); req_timer = 1'b0;
        wait_to(t + 2); chk("t1_busy_take", 32'(busy), 1);
        wait_to(t + 3); chk("t1_in_service", 32'(in_service), 32'h1);
        chk("t1_pending_clr", 32'(pending), 0);
        wait_to(t + 7); reti = 1'b1; exp_ret(10'h012, t + 8);
        step(); reti = 1'b0;
        wait_to(t + 9); chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_in_service_clr", 32'(in_service), 0);

        // Simultaneous port + syscall: port first, syscall two cycles after ret_valid
        wait_to(t + 12);
        t = cyc; pc_cur = 10'h040; req_port = 1'b1; req_syscall = 1'b1;
        exp_take(10'h3FC, t + 2);
        step(); req_port = 1'b0; req_syscall = 1'b0;
        wait_to(t + 3); chk("t2_pending", 32'(pending), 32'h2);
        chk("t2_in_service", 32'(in_service), 32'h4);
        wait_to(t + 5); reti = 1'b1;
        exp_ret(10'h040, t + 6); exp_take(10'h3FD, t + 8);
        step(); reti = 1'b0;
        wait_to(t + 9); chk("t2_in_service_sys", 32'(in_service), 32'h2);
        wait_to(t + 10); reti = 1'b1; exp_ret(10'h040, t + 11);
        step(); reti = 1'b0;

        // Mask everything: timer stays pending, exception still taken, unmask releases timer
        wait_to(t + 14);
        t = cyc; mask_we = 1'b1; mask_wdata = 4'b0000;
        step(); mask_we = 1'b0; req_timer = 1'b1;
        step(); req_timer = 1'b0;
        wait_to(t + 5); chk("t3_pending_masked", 32'(pending), 32'h1);
        chk("t3_no_take_busy", 32'(busy), 0);
        pc_cur = 10'h077; req_exc = 1'b1; exp_take(10'h3FB, t + 7);
        step(); req_exc = 1'b0;
        wait_to(t + 8); chk("t3_pending_keep", 32'(pending), 32'h1);
        chk("t3_in_service_exc", 32'(in_service), 32'h8);
        wait_to(t + 9); reti = 1'b1; exp_ret(10'h077, t + 10);
        step(); reti = 1'b0; mask_we = 1'b1; mask_wdata = 4'b1111; exp_take(10'h3FA, t + 12);
        step(); mask_we = 1'b0;
        wait_to(t + 14); reti = 1'b1; exp_ret(10'h077, t + 15);
        step(); reti = 1'b0;

        // Stall holds off the take; reti in IDLE is ignored
        wait_to(t + 18);
        t = cyc; pc_cur = 10'h100; stall = 1'b1; req_exc = 1'b1; exp_take(10'h3FB, t + 7);
        step(); req_exc = 1'b0;
        wait_to(t + 3); chk("t4_stall_no_take", 32'(irq_take), 0);
        chk("t4_stall_pending", 32'(pending), 32'h8);
        wait_to(t + 6); stall = 1'b0;
        wait_to(t + 10); reti = 1'b1; exp_ret(10'h100, t + 11);
        step(); reti = 1'b0;
        wait_to(t + 14); reti = 1'b1;
        step(); reti = 1'b0;
        step(); chk("t4_idle_reti", 32'(ret_valid), 0);
        chk("t4_idle_busy", 32'(busy), 0);

        // Preemption (nested build) or deferral (flat build) of timer by exception
        wait_to(t + 18);
        t = cyc; pc_cur = 10'h020; req_timer = 1'b1; exp_take(10'h3FA, t + 2);
        step(); req_timer = 1'b0;
        wait_to(t + 4); pc_cur = 10'h030; req_exc = 1'b1;
`ifdef IRQ_NEST_EN
        exp_take(10'h3FB, t + 6);
        step(); req_exc = 1'b0;
        wait_to(t + 7); chk("t6_in_service_exc", 32'(in_service), 32'h8);
        wait_to(t + 8); reti = 1'b1; exp_ret(10'h030, t + 9);
        step(); reti = 1'b0;
        wait_to(t + 10); chk("t6_in_service_pop", 32'(in_service), 32'h1);
        chk("t6_busy_nested", 32'(busy), 1);
        wait_to(t + 11); reti = 1'b1; exp_ret(10'h020, t + 12);
        step(); reti = 1'b0;
        wait_to(t + 13); chk("t6_busy_idle", 32'(busy), 0);
        chk("t6_in_service_clr", 32'(in_service), 0);
`else
        step(); req_exc = 1'b0;
        wait_to(t + 7); chk("t6_no_preempt", 32'(in_service), 32'h1);
        chk("t6_exc_waits", 32'(pending), 32'h8);
        wait_to(t + 8); reti = 1'b1; exp_ret(10'h020, t + 9); exp_take(10'h3FB, t + 11);
        step(); reti = 1'b0;
        wait_to(t + 13); reti = 1'b1; exp_ret(10'h030, t + 14);
        step(); reti = 1'b0;
        wait_to(t + 15); chk("t6_busy_idle", 32'(busy), 0);
`endif

        // Reset during SERVICE aborts with no return and drops pending requests
        wait_to(t + 18);
        t = cyc; pc_cur = 10'h155; req_port = 1'b1; exp_take(10'h3FC, t + 2);
        step(); req_port = 1'b0;
        wait_to(t + 3); req_timer = 1'b1;
        step(); req_timer = 1'b0;
        chk("t5_pending_before", 32'(pending), 32'h1);
        chk("t5_in_service_before", 32'(in_service), 32'h4);
        reset = 1'b1;
        step();
        chk("t5_irq_take", 32'(irq_take), 0);
        chk("t5_ret_valid", 32'(ret_valid), 0);
        chk("t5_vec_out", 32'(vec_out), 0);
        chk("t5_ret_pc", 32'(ret_pc), 0);
        chk("t5_pending", 32'(pending), 0);
        chk("t5_in_service", 32'(in_service), 0);
        chk("t5_busy", 32'(busy), 0);
        reset = 1'b0;
        wait_to(t + 10);
        chk("t5_no_take_after", 32'(busy), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
